mem_responder: RTL and testbench

- Unified instruction/data memory that answers the multicycle datapath's memory accesses: it receives address, write data and write enable, and returns read data.
- Word-organised, byte-addressed, with a configurable number of wait states.
- Exposes a ready/busy handshake so the control FSM can stall while an access is in flight.
- Sits between the datapath/control pair and the simulation memory image.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 83 ++++++++
 tb/tb_mem_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the datapath and the memory responder
interface mem_responder_if #(
    parameter int WIDTH = 32
);
    logic             req_i;
    logic             we_i;
    logic [WIDTH-1:0] addr_i;
    logic [WIDTH-1:0] wdata_i;
    logic [WIDTH-1:0] rdata_o;
    logic             ready_o;
    logic             busy_o;
    logic             err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ready_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ready_o, busy_o, err_o
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-organised memory with fixed wait-state latency and a ready/busy/err handshake
module mem_responder #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic                  we_q, err_q, go, a_we, a_bad;
    logic [WIDTH-1:0]      addr_q, wdata_q, rdata_q, a_addr, a_wdata;
    logic [DEPTH_LOG2-1:0] a_idx;

    // Next state and wait counter; go marks the edge that performs the access and enters RESP
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        go      = 1'b0;
        case (state)
            IDLE: if (bus.req_i) begin
                cnt_n   = LAT;
                state_n = (LAT != 4'd0) ? WAIT : RESP;
                go      = (LAT == 4'd0);
            end
            WAIT: begin
                cnt_n   = cnt - 4'd1;
                state_n = (cnt == 4'd1) ? RESP : WAIT;
                go      = (cnt == 4'd1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Zero latency accesses happen on the acceptance edge, so they use the live request fields
    assign a_we    = (state == IDLE) ? bus.we_i    : we_q;
    assign a_addr  = (state == IDLE) ? bus.addr_i  : addr_q;
    assign a_wdata = (state == IDLE) ? bus.wdata_i : wdata_q;
    assign a_bad   = (|a_addr[1:0]) || (|(a_addr >> (DEPTH_LOG2 + 2)));
    assign a_idx   = a_addr[DEPTH_LOG2+1:2];

    // Control registers, request latch, error flag and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && bus.req_i) begin
                we_q    <= bus.we_i;
                addr_q  <= bus.addr_i;
                wdata_q <= bus.wdata_i;
            end
            if (go) begin
                err_q <= a_bad;
                if (!a_bad && !a_we) rdata_q <= mem[a_idx];
            end
        end
    end

    // Storage is never reset; reset only blocks a write that has not yet committed
    always_ff @(posedge clk) begin
        if (!rst && go && !a_bad && a_we) mem[a_idx] <= a_wdata;
    end

    assign bus.rdata_o = rdata_q;
    assign bus.ready_o = (state == RESP);
    assign bus.busy_o  = (state != IDLE);
    assign bus.err_o   = (state == RESP) && err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table, hand-written and randomized checks of two latency builds against a word-memory model
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_responder_if #(.WIDTH(32)) b2 ();
    mem_responder_if #(.WIDTH(32)) b0 ();

    mem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    mem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    always #5 clk = ~clk;

    // Model: per build, a word array, which words have been written, and the rdata last returned
    logic [31:0] rmem  [2][1024];
    bit          known [2][1024];
    logic [31:0] cur   [2];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", n, act, want);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", n, act, want);
        end
    endtask

    // s=0 selects the LATENCY=2 build, s=1 the LATENCY=0 build
    task automatic drive(input bit s, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (s) begin
            b0.req_i = r; b0.we_i = w; b0.addr_i = a; b0.wdata_i = d;
        end else begin
            b2.req_i = r; b2.we_i = w; b2.addr_i = a; b2.wdata_i = d;
        end
    endtask

    function automatic logic [31:0] rd_of(input bit s);
        return s ? b0.rdata_o : b2.rdata_o;
    endfunction
    function automatic logic rdy_of(input bit s);
        return s ? b0.ready_o : b2.ready_o;
    endfunction
    function automatic logic busy_of(input bit s);
        return s ? b0.busy_o : b2.busy_o;
    endfunction
    function automatic logic err_of(input bit s);
        return s ? b0.err_o : b2.err_o;
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    endfunction

    task automatic check_idle(input bit s, input string tag);
        chk1({tag, "_ready"}, rdy_of(s), 1'b0);
        chk1({tag, "_busy"}, busy_of(s), 1'b0);
        chk1({tag, "_err"}, err_of(s), 1'b0);
        chk({tag, "_rdata"}, rd_of(s), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        cur[0] = 32'd0;
        cur[1] = 32'd0;
    endtask

    // One access with the request fields scrambled right after acceptance; completion timing is exact
    task automatic access(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rexp, input bit eexp);
        int lat = s ? 0 : 2;
        drive(s, 1, w, a, d);
        @(negedge clk);
        drive(s, 0, 1'($urandom), $urandom, $urandom);
        for (int c = 1; c <= lat; c++) begin
            chk1("wait_ready", rdy_of(s), 1'b0);
            chk1("wait_busy", busy_of(s), 1'b1);
            @(negedge clk);
        end
        chk1("resp_ready", rdy_of(s), 1'b1);
        chk1("resp_busy", busy_of(s), 1'b1);
        chk1("resp_err", err_of(s), eexp);
        chk("resp_rdata", rd_of(s), rexp);
        @(negedge clk);
        chk1("after_ready", rdy_of(s), 1'b0);
        chk1("after_busy", busy_of(s), 1'b0);
        chk1("after_err", err_of(s), 1'b0);
        drive(s, 0, 0, 0, 0);
        if (!bad_addr(a)) begin
            if (w) begin
                rmem[s][a[11:2]]  = d;
                known[s][a[11:2]] = 1'b1;
            end else begin
                cur[s] = rmem[s][a[11:2]];
            end
        end
    endtask

    initial begin
        logic [31:0] hv [3];
        logic [31:0] ha [4];
        tbl[0]  = '{0, 32'h0000_0000, 32'h0,          32'h2008_0005, 0};
        tbl[1]  = '{1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h2008_0005, 0};
        tbl[2]  = '{0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 0};
        tbl[3]  = '{0, 32'h0000_0006, 32'h0,          32'hDEAD_BEEF, 1};
        tbl[4]  = '{1, 32'h0000_1000, 32'h1111_1111, 32'hDEAD_BEEF, 1};
        tbl[5]  = '{0, 32'h0000_0000, 32'h0,          32'h2008_0005, 0};
        tbl[6]  = '{1, 32'h0000_0030, 32'h0BAD_F00D, 32'h2008_0005, 0};
        tbl[7]  = '{0, 32'h0000_0030, 32'h0,          32'h0BAD_F00D, 0};
        tbl[8]  = '{1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0BAD_F00D, 0};
        tbl[9]  = '{0, 32'h0000_0FFC, 32'h0,          32'hA5A5_A5A5, 0};
        tbl[10] = '{0, 32'h8000_0000, 32'h0,          32'hA5A5_A5A5, 1};
        tbl[11] = '{1, 32'h0000_0020, 32'hCAFE_F00D, 32'hA5A5_A5A5, 0};
        tbl[12] = '{0, 32'h0000_0020, 32'h0,          32'hCAFE_F00D, 0};
        tbl[13] = '{0, 32'h0000_1001, 32'h0,          32'hCAFE_F00D, 1};
        for (int s = 0; s < 2; s++) for (int i = 0; i < 1024; i++) known[s][i] = 1'b0;
        cur[0] = 32'd0;
        cur[1] = 32'd0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        check_idle(0, "rst2");
        check_idle(1, "rst0");
        rst = 1'b0;

        // Memory image word 0, then a reset that must not disturb it
        access(0, 1, 32'h0, 32'h2008_0005, 32'd0, 0);
        do_reset();
        check_idle(0, "rst_keep");

        for (int i = 0; i < 14; i++)
            access(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err);

        // Reset during WAIT of a write: no completion, and the old word survives
        drive(0, 1, 1, 32'h20, 32'h1234_5678);
        @(negedge clk);
        chk1("abort_busy", b2.busy_o, 1'b1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        cur[0] = 32'd0;
        cur[1] = 32'd0;
        check_idle(0, "abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("abort_noready", b2.ready_o, 1'b0);
        end
        access(0, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0);

        // Zero latency with req held high: one completion every other cycle, address taken at acceptance
        access(1, 1, 32'h40, 32'hAAAA_0001, 32'd0, 0);
        access(1, 1, 32'h44, 32'hBBBB_0002, 32'd0, 0);
        hv[0] = 32'hAAAA_0001; hv[1] = 32'hBBBB_0002; hv[2] = 32'hAAAA_0001;
        ha[0] = 32'h40; ha[1] = 32'h44; ha[2] = 32'h40; ha[3] = 32'h40;
        drive(1, 1, 0, ha[0], 32'h0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk1("l0_ready", b0.ready_o, 1'(i % 2));
            chk1("l0_busy", b0.busy_o, 1'(i % 2));
            if (i % 2 == 1) begin
                chk("l0_rdata", b0.rdata_o, hv[i/2]);
                drive(1, 1, 0, ha[i/2+1], 32'h0);
            end
        end
        drive(1, 0, 0, 0, 0);
        cur[1] = 32'hAAAA_0001;

        // Randomized mix on both builds against the model
        for (int n = 0; n < 80; n++) begin
            bit          s = 1'($urandom);
            bit          w = 1'($urandom);
            int          kind = $urandom_range(0, 9);
            logic [31:0] a;
            logic [31:0] d = $urandom;
            logic [31:0] rexp;
            a = (kind == 9) ? 32'hFFC : 32'($urandom_range(0, 63)) << 2;
            if (kind == 0) a = a | 32'($urandom_range(1, 3));
            if (kind == 1) a = a | 32'h1000 | (32'($urandom) & 32'hFFFF_E000);
            if (!w && !bad_addr(a) && !known[s][a[11:2]]) w = 1'b1;
            rexp = (!bad_addr(a) && !w) ? rmem[s][a[11:2]] : cur[s];
            access(s, w, a, d, rexp, bad_addr(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
